regfile_wr_ctrl: RTL
====================

# regfile_wr_ctrl

Write-port controller for the 32-entry register file. It owns the file's single write port (WE3/AD3/WD3) and performs a zero-fill sweep after reset or on request, because the file itself has no reset. It then arbitrates round-robin between two writeback requesters using valid/ready handshakes, and drops writes to x0 so that x0 always reads zero. It sits between the writeback stage(s) and the register file.

## Interface

- DATA_WIDTH, 32, write data width
- ADDR_WIDTH, 5, register address width; N = 2**ADDR_WIDTH entries
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- clr  in  1  synchronous request to re-run the zero-fill sweep (honoured in RUN only)
- a_valid  in  1  requester A (primary writeback) has a write
- a_addr  in  ADDR_WIDTH  A destination register
- a_data  in  DATA_WIDTH  A write data
- a_ready  out  1  A write accepted this cycle
- b_valid  in  1  requester B (secondary/multi-cycle writeback) has a write
- b_addr  in  ADDR_WIDTH  B destination register
- b_data  in  DATA_WIDTH  B write data
- b_ready  out  1  B write accepted this cycle
- WE3  out  1  register-file write enable (registered)
- AD3  out  ADDR_WIDTH  register-file write address (registered)
- WD3  out  DATA_WIDTH  register-file write data (registered)
- init_done  out  1  high in RUN; register file fully zeroed and writable

## Operation

- States: CLEAR, FLUSH, RUN. Reset state is CLEAR.
- Reset values: state=CLEAR, clr_cnt=0, last_grant=B (A wins the first tie), WE3=0, AD3=0, WD3=0, init_done=0, a_ready=0, b_ready=0.
- CLEAR: each cycle the output register loads WE3=1, AD3=clr_cnt, WD3=0, and clr_cnt increments.
  - When clr_cnt = N-1 is issued, the next state is FLUSH and clr_cnt wraps to 0.
- FLUSH: a single cycle. Output register loads WE3=0. Next state is RUN.
- RUN:
  - a_ready = a_valid && (!b_valid || last_grant==B).
  - b_ready = b_valid && (!a_valid || last_grant==A).
  - Both ready signals are combinational from the valid signals and last_grant. They are never both high.
  - A transfer happens when valid && ready. On a transfer, last_grant updates to the granted side.
  - On a transfer with addr≠0, the output register loads WE3=1, AD3=addr, WD3=data.
  - On a transfer with addr=0, the request is accepted and last_grant updates, but WE3 loads 0.
  - With no transfer, WE3 loads 0 and AD3/WD3 hold their values.
- clr in RUN: that cycle a_ready=b_ready=0 and WE3 loads 0. The next state is CLEAR with clr_cnt=0. clr is ignored in CLEAR and FLUSH.
- Requester rule: valid, addr and data stay stable until accepted. valid must not depend on ready.
- In CLEAR and FLUSH both readies are 0. Pending requests wait; none are lost or reordered per requester.
- Async reset in any state: all outputs return to reset values immediately. The sweep restarts from 0 after release.

## Timing

- Edge 1 is the first rising edge with rst_n high.
- Clear sweep:
  - Edges 1..N load AD3=0..N-1 with WE3=1, so WE3 is high for N consecutive cycles.
  - The register file writes at edges 2..N+1.
  - State enters FLUSH at edge N and RUN at edge N+1; init_done rises after edge N+1.
  - For N=32, the first acceptance is possible at edge 34.
- Write latency: a request accepted at edge k drives WE3/AD3/WD3 during cycle k→k+1. The register file captures it at edge k+1.
- Throughput: one accepted write per cycle in RUN.
- Under continuous contention, grants strictly alternate A, B, A, B, …
- Every write in flight when init_done rises belongs to the sweep and lands before any requester write.

## Test plan

- Reset/sweep:
  - Stimulus: rst_n low 3 cycles, then release.
  - Response: WE3=1 for exactly 32 cycles with AD3=0..31 and WD3=0. init_done=1 after edge 33, and all 32 registers read 0.
- Single requester:
  - Stimulus: in RUN, a_valid=1, a_addr=5, a_data=0xDEADBEEF, b_valid=0.
  - Response: a_ready=1 the same cycle. The next cycle has WE3=1, AD3=5, WD3=0xDEADBEEF for exactly one cycle, and x5 reads 0xDEADBEEF.
- Contention:
  - Stimulus: A and B valid continuously for 6 writes each, A to x1..x6 with 0xA0+i, B to x11..x16 with 0xB0+i.
  - Response: grants go A,B,A,B… starting with A. All 12 writes land with correct data, and no write is dropped or duplicated.
- x0 write:
  - Stimulus: b_valid=1, b_addr=0, b_data=0x1234.
  - Response: b_ready=1, WE3 stays 0 and x0 reads 0. With A and B both valid afterwards, A wins the tie (last_grant=B).
- clr mid-run:
  - Stimulus: pulse clr while A holds a write to x7 = 0x55.
  - Response: a_ready=0 that cycle. A 32-entry zero sweep follows, then A is accepted right after init_done. x7 ends at 0x55; all other registers read 0.
- Reset mid-sweep:
  - Stimulus: drop rst_n when AD3=12 during CLEAR.
  - Response: WE3, AD3, WD3 and init_done go to 0 immediately. After release, the sweep restarts at AD3=0 and runs the full 32 cycles.

Source files
------------

// File: rtl/regfile_wr_ctrl_if.sv
// Bundle between the writeback requesters and the register-file write controller:
// two valid/ready request channels plus the registered write port and init status.
interface regfile_wr_ctrl_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic                  a_valid;
  logic [ADDR_WIDTH-1:0] a_addr;
  logic [DATA_WIDTH-1:0] a_data;
  logic                  a_ready;

  logic                  b_valid;
  logic [ADDR_WIDTH-1:0] b_addr;
  logic [DATA_WIDTH-1:0] b_data;
  logic                  b_ready;

  logic                  WE3;
  logic [ADDR_WIDTH-1:0] AD3;
  logic [DATA_WIDTH-1:0] WD3;
  logic                  init_done;

  modport master (
    output a_valid, a_addr, a_data, b_valid, b_addr, b_data,
    input  a_ready, b_ready, WE3, AD3, WD3, init_done
  );

  modport slave (
    input  a_valid, a_addr, a_data, b_valid, b_addr, b_data,
    output a_ready, b_ready, WE3, AD3, WD3, init_done
  );
endinterface

// File: rtl/regfile_wr_ctrl.sv
// Owns the register file's single write port: zero-fill sweep after reset or clr,
// then round-robin arbitration of two writeback requesters with x0 writes dropped.
module regfile_wr_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  regfile_wr_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    FLUSH = 2'd1,
    RUN   = 2'd2
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] clr_cnt;
  logic                  last_b;

  logic                  we_p0;
  logic [ADDR_WIDTH-1:0] ad_p0;
  logic [DATA_WIDTH-1:0] wd_p0;
  logic                  init_p0;

  logic                  a_rdy;
  logic                  b_rdy;

  // x0 is hardwired to zero, so accepted writes to it never reach the file.
  function automatic logic writable(input logic [ADDR_WIDTH-1:0] addr);
    return addr != '0;
  endfunction

  always_comb begin
    a_rdy = 1'b0;
    b_rdy = 1'b0;
    if (state == RUN && !clr) begin
      a_rdy = bus.a_valid && (!bus.b_valid || last_b);
      b_rdy = bus.b_valid && (!bus.a_valid || !last_b);
    end
  end

  // p0: request accepted at this edge becomes the registered write port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= CLEAR;
      clr_cnt <= '0;
      last_b  <= 1'b1;
      we_p0   <= 1'b0;
      ad_p0   <= '0;
      wd_p0   <= '0;
      init_p0 <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          we_p0   <= 1'b1;
          ad_p0   <= clr_cnt;
          wd_p0   <= '0;
          clr_cnt <= clr_cnt + ADDR_WIDTH'(1);
          if (&clr_cnt) state <= FLUSH;
        end
        FLUSH: begin
          we_p0   <= 1'b0;
          init_p0 <= 1'b1;
          state   <= RUN;
        end
        RUN: begin
          if (clr) begin
            we_p0   <= 1'b0;
            init_p0 <= 1'b0;
            clr_cnt <= '0;
            state   <= CLEAR;
          end else if (a_rdy) begin
            last_b <= 1'b0;
            we_p0  <= writable(bus.a_addr);
            if (writable(bus.a_addr)) begin
              ad_p0 <= bus.a_addr;
              wd_p0 <= bus.a_data;
            end
          end else if (b_rdy) begin
            last_b <= 1'b1;
            we_p0  <= writable(bus.b_addr);
            if (writable(bus.b_addr)) begin
              ad_p0 <= bus.b_addr;
              wd_p0 <= bus.b_data;
            end
          end else begin
            we_p0 <= 1'b0;
          end
        end
        default: begin
          we_p0   <= 1'b0;
          init_p0 <= 1'b0;
          clr_cnt <= '0;
          state   <= CLEAR;
        end
      endcase
    end
  end

  assign bus.a_ready   = a_rdy;
  assign bus.b_ready   = b_rdy;
  assign bus.WE3       = we_p0;
  assign bus.AD3       = ad_p0;
  assign bus.WD3       = wd_p0;
  assign bus.init_done = init_p0;

endmodule
